// File: rtl/axi4l_arbiter.sv
// N-to-1 AXI4-Lite arbiter: one outstanding transaction at a time, round-robin between requesters.
// All channel signals pass straight through to the granted requester; nothing is buffered here.
module axi4l_arbiter #(
    parameter int unsigned N = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [N*32-1:0] i_in_awaddr,
    input  logic [N*3-1:0]  i_in_awprot,
    input  logic [N-1:0]    i_in_awvalid,
    output logic [N-1:0]    o_in_awready,
    input  logic [N*32-1:0] i_in_wdata,
    input  logic [N*4-1:0]  i_in_wstrb,
    input  logic [N-1:0]    i_in_wvalid,
    output logic [N-1:0]    o_in_wready,
    output logic [1:0]      o_in_bresp,
    output logic [N-1:0]    o_in_bvalid,
    input  logic [N-1:0]    i_in_bready,
    input  logic [N*32-1:0] i_in_araddr,
    input  logic [N*3-1:0]  i_in_arprot,
    input  logic [N-1:0]    i_in_arvalid,
    output logic [N-1:0]    o_in_arready,
    output logic [31:0]     o_in_rdata,
    output logic [1:0]      o_in_rresp,
    output logic [N-1:0]    o_in_rvalid,
    input  logic [N-1:0]    i_in_rready,
    output logic [31:0]     o_out_awaddr,
    output logic [2:0]      o_out_awprot,
    output logic            o_out_awvalid,
    input  logic            i_out_awready,
    output logic [31:0]     o_out_wdata,
    output logic [3:0]      o_out_wstrb,
    output logic            o_out_wvalid,
    input  logic            i_out_wready,
    input  logic [1:0]      i_out_bresp,
    input  logic            i_out_bvalid,
    output logic            o_out_bready,
    output logic [31:0]     o_out_araddr,
    output logic [2:0]      o_out_arprot,
    output logic            o_out_arvalid,
    input  logic            i_out_arready,
    input  logic [31:0]     i_out_rdata,
    input  logic [1:0]      i_out_rresp,
    input  logic            i_out_rvalid,
    output logic            o_out_rready
);

    localparam int unsigned GW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StB} state_e;

    state_e          r_state;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_last;
    logic            r_aw_done;
    logic            r_w_done;

    logic [N-1:0]    w_req;
    logic [N-1:0]    w_gsel;
    logic [GW-1:0]   w_idx;
    logic [GW-1:0]   w_winner;
    logic            w_found;
    logic            w_win_wr;
    logic            w_g_awvalid;
    logic            w_g_wvalid;
    logic            w_g_arvalid;
    logic            w_g_rready;
    logic            w_g_bready;
    logic            w_st_ar;
    logic            w_st_r;
    logic            w_st_aw;
    logic            w_st_b;
    logic            w_aw_fin;
    logic            w_w_fin;

    assign w_req   = i_in_arvalid | i_in_awvalid;
    assign w_st_ar = (r_state == StAr);
    assign w_st_r  = (r_state == StR);
    assign w_st_aw = (r_state == StAw);
    assign w_st_b  = (r_state == StB);

    // Round-robin scan starting just after the last requester served.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_win_wr = 1'b0;
        w_idx    = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            w_idx = GW'((32'(r_last) + k) % N);
            if (!w_found && w_req[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
                w_win_wr = i_in_awvalid[w_idx];
            end
        end
    end

    always_comb begin
        o_out_awaddr = '0;
        o_out_awprot = '0;
        o_out_wdata  = '0;
        o_out_wstrb  = '0;
        o_out_araddr = '0;
        o_out_arprot = '0;
        w_g_awvalid  = 1'b0;
        w_g_wvalid   = 1'b0;
        w_g_arvalid  = 1'b0;
        w_g_rready   = 1'b0;
        w_g_bready   = 1'b0;
        w_gsel       = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (r_grant == GW'(i)) begin
                w_gsel[i]    = 1'b1;
                o_out_awaddr = i_in_awaddr[i*32 +: 32];
                o_out_awprot = i_in_awprot[i*3 +: 3];
                o_out_wdata  = i_in_wdata[i*32 +: 32];
                o_out_wstrb  = i_in_wstrb[i*4 +: 4];
                o_out_araddr = i_in_araddr[i*32 +: 32];
                o_out_arprot = i_in_arprot[i*3 +: 3];
                w_g_awvalid  = i_in_awvalid[i];
                w_g_wvalid   = i_in_wvalid[i];
                w_g_arvalid  = i_in_arvalid[i];
                w_g_rready   = i_in_rready[i];
                w_g_bready   = i_in_bready[i];
            end
        end
    end

    // Address and data of a write complete independently; sticky flags mask repeats.
    assign o_out_awvalid = w_st_aw & w_g_awvalid & ~r_aw_done;
    assign o_out_wvalid  = w_st_aw & w_g_wvalid & ~r_w_done;
    assign o_out_arvalid = w_st_ar & w_g_arvalid;
    assign o_out_rready  = w_st_r & w_g_rready;
    assign o_out_bready  = w_st_b & w_g_bready;

    assign o_in_awready = w_gsel & {N{w_st_aw & ~r_aw_done & i_out_awready}};
    assign o_in_wready  = w_gsel & {N{w_st_aw & ~r_w_done & i_out_wready}};
    assign o_in_arready = w_gsel & {N{w_st_ar & i_out_arready}};
    assign o_in_rvalid  = w_gsel & {N{w_st_r & i_out_rvalid}};
    assign o_in_bvalid  = w_gsel & {N{w_st_b & i_out_bvalid}};
    assign o_in_rdata   = i_out_rdata;
    assign o_in_rresp   = i_out_rresp;
    assign o_in_bresp   = i_out_bresp;

    assign w_aw_fin = r_aw_done | (o_out_awvalid & i_out_awready);
    assign w_w_fin  = r_w_done | (o_out_wvalid & i_out_wready);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_grant   <= '0;
            r_last    <= GW'(N - 1);
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_state <= w_win_wr ? StAw : StAr;
                    end
                end
                StAr: begin
                    if (o_out_arvalid && i_out_arready) begin
                        r_state <= StR;
                    end
                end
                StR: begin
                    if (i_out_rvalid && o_out_rready) begin
                        r_state <= StIdle;
                        r_last  <= r_grant;
                    end
                end
                StAw: begin
                    if (w_aw_fin && w_w_fin) begin
                        r_state   <= StB;
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end else begin
                        r_aw_done <= w_aw_fin;
                        r_w_done  <= w_w_fin;
                    end
                end
                StB: begin
                    if (i_out_bvalid && o_out_bready) begin
                        r_state <= StIdle;
                        r_last  <= r_grant;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/axi4l_arbiter.md
Name: axi4l_arbiter

Overview:
- N-to-1 AXI4-Lite arbiter. Shares one downstream AXI4-Lite slave port (interconnect/peripheral bus) between N requesters, e.g. core instruction and data ports.
- Single outstanding transaction system-wide; read or write granted atomically from address phase to response.
- Round-robin fairness across requesters.
- Payload types (addr 32, data 32, strb 4, prot 3, resp 2) are the team's AXI4-Lite package types.

Parameters:
N, 2, number of requesters (2..8)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_awaddr/in_awprot/in_awvalid  in  N*32/N*3/N  requester write address channel
in_awready  out  N  write address ready per requester
in_wdata/in_wstrb/in_wvalid  in  N*32/N*4/N  requester write data channel
in_wready  out  N  write data ready per requester
in_bresp  out  2  write response (shared, qualify with in_bvalid)
in_bvalid  out  N  write response valid per requester
in_bready  in  N  write response ready
in_araddr/in_arprot/in_arvalid  in  N*32/N*3/N  requester read address channel
in_arready  out  N  read address ready per requester
in_rdata/in_rresp  out  32/2  read data/response (shared, qualify with in_rvalid)
in_rvalid  out  N  read data valid per requester
in_rready  in  N  read data ready
out_awaddr/out_awprot/out_awvalid  out  32/3/1  downstream write address
out_awready  in  1
out_wdata/out_wstrb/out_wvalid  out  32/4/1  downstream write data
out_wready  in  1
out_bresp/out_bvalid  in  2/1; out_bready  out  1
out_araddr/out_arprot/out_arvalid  out  32/3/1  downstream read address
out_arready  in  1
out_rdata/out_rresp/out_rvalid  in  32/2/1; out_rready  out  1

Behaviour:
- Single clock clk; reset synchronous active-high. Reset: state IDLE, grant=0, last=N-1 (requester 0 wins first). All out_*valid, out_*ready, in_*valid, in_*ready are 0.
- States: IDLE, AR, R, AW, B.
- IDLE: requester i is requesting if in_arvalid[i] | in_awvalid[i]. Winner is the first requesting index scanning last+1, last+2, … modulo N. Winner registered as grant.
  - Next state AW if in_awvalid[grant], else AR: write beats read within one requester.
  - No requests: stay IDLE.
  - Arbitration costs exactly 1 cycle: request at cycle t gives out_*valid at t+1.
- AR: out_ar* = in_ar*[grant]; in_arready[grant] = out_arready (combinational). On out_arvalid & out_arready -> R.
- R: in_rvalid[grant] = out_rvalid; out_rready = in_rready[grant]; in_rdata/in_rresp = out_rdata/out_rresp passed through unmodified. On handshake -> IDLE, last = grant.
- AW: AW and W forwarded independently from requester grant, with sticky flags aw_done and w_done.
  - out_awvalid = in_awvalid[grant] & ~aw_done. out_wvalid = in_wvalid[grant] & ~w_done.
  - Matching readies pass through, gated the same way.
  - Same-cycle and any-order completion allowed. When both are done (including same cycle) -> B; flags clear.
- B: in_bvalid[grant] = out_bvalid; out_bready = in_bready[grant]. On handshake -> IDLE, last = grant.
- Non-granted requesters: all in_*ready and in_*valid held 0 for the whole transaction. Their requests stay pending, with no loss.
- out_* payloads are muxed from grant in every state; don't-care when valid is low.
- Only combinational paths: ready/valid/payload passthrough. No buffering inside the arbiter.
- New arrivals during a transaction do not preempt it. They compete at the next IDLE.
- Back-to-back: IDLE is always visited between transactions, giving 1 idle bus cycle per transaction.
- Reset mid-transaction returns to IDLE and abandons the transaction. The whole fabric is reset together.
- Requester dropping valid before its handshake is a protocol violation; the arbiter waits in state indefinitely.

Test Plan:
- Single read: req 0 araddr=0x1000, slave rdata=0xDEADBEEF rresp=OKAY -> out_arvalid at t+1, in_rvalid[0] with 0xDEADBEEF, in_rvalid[1]=0 throughout.
- Contention: req 0 and req 1 both arvalid every cycle, 8 reads -> grants alternate 0,1,0,1…, first grant 0 after reset.
- Write split: req 1 awaddr=0x20, wdata=0x55AA55AA, strb=0xF; out_wready 3 cycles before out_awready -> B entered only after both handshakes; bresp=SLVERR returned to req 1 only.
- Read+write same requester: req 0 awvalid and arvalid together -> write completes first, read granted next IDLE (or req 1 if pending, per round-robin).
- Backpressure: in_rready[0]=0 for 5 cycles with out_rvalid=1 -> out_rready=0, data held, no new grant; completes when ready rises.
- Reset in R state -> next cycle IDLE, all valids/readies 0, grant restarts at requester 0.
